// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed byte stream (length, program, checksum),
// writes the program bytes into IMEM, and holds the CPU until a frame passes its checksum.
module imem_loader #(
  parameter int unsigned          ADDR_W       = 8,
  parameter logic [ADDR_W-1:0]    BASE_ADDR    = '0,
  parameter int unsigned          TIMEOUT      = 1000,
  parameter bit                   RUN_ON_RESET = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_run,
  output logic              pc_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [7:0]        imem_wdata_q, imem_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              pc_rst_q, pc_rst_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic [8:0]        count_q, count_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic       xfer;
  logic       active;
  logic [7:0] chk_sum;

  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_run_d    = cpu_run_q;
    pc_rst_d     = 1'b0;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    count_d      = count_q;
    sum_d        = sum_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    xfer         = in_valid & in_ready_q;
    active       = (state_q == S_HEADER) || (state_q == S_LOAD) || (state_q == S_CHECK);
    chk_sum      = sum_q + in_data;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_start) begin
          state_d     = S_HEADER;
          cpu_run_d   = 1'b0;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
          timer_d     = '0;
        end
      end
      S_HEADER: begin
        if (xfer) begin
          count_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          sum_d   = '0;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = BASE_ADDR + idx_q;
          imem_wdata_d = in_data;
          sum_d        = chk_sum;
          idx_d        = idx_q + 1'b1;
          count_d      = count_q - 9'd1;
          if (count_q == 9'd1) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (chk_sum == 8'd0) begin
            state_d     = S_DONE;
            cpu_run_d   = 1'b1;
            load_done_d = 1'b1;
            pc_rst_d    = 1'b1;
          end else begin
            state_d    = S_ERROR;
            cpu_run_d  = 1'b0;
            load_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inactivity watchdog runs only while a frame is open; any transfer rearms it.
    if (active) begin
      if (xfer) begin
        timer_d = '0;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        state_d    = S_ERROR;
        cpu_run_d  = 1'b0;
        load_err_d = 1'b1;
        timer_d    = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    in_ready_d = (state_d == S_HEADER) || (state_d == S_LOAD) || (state_d == S_CHECK);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= '0;
      cpu_run_q    <= RUN_ON_RESET;
      pc_rst_q     <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      count_q      <= '0;
      sum_q        <= '0;
      idx_q        <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_run_q    <= cpu_run_d;
      pc_rst_q     <= pc_rst_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      count_q      <= count_d;
      sum_q        <= sum_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign pc_rst     = pc_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 / hold on reset, base 0xFE / run on reset)
// see identical framed streams; expected writes and outcomes come from a frame-level model.
module tb_imem_loader;

  localparam int unsigned TO = 40;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load_start;
  logic       in_valid;
  logic [7:0] in_data;

  logic       rdy_a, we_a, run_a, pc_a, done_a, err_a;
  logic [7:0] addr_a, wdata_a;
  logic       rdy_b, we_b, run_b, pc_b, done_b, err_b;
  logic [7:0] addr_b, wdata_b;

  int passed = 0;
  int total  = 0;
  logic [7:0] frame_q[$];

  always #5 clock = ~clock;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00), .TIMEOUT(TO), .RUN_ON_RESET(1'b0)) dut_a (
    .clock(clock), .reset_n(reset_n), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(rdy_a), .imem_we(we_a), .imem_addr(addr_a),
    .imem_wdata(wdata_a), .cpu_run(run_a), .pc_rst(pc_a), .load_done(done_a),
    .load_err(err_a)
  );

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE), .TIMEOUT(TO), .RUN_ON_RESET(1'b1)) dut_b (
    .clock(clock), .reset_n(reset_n), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(rdy_b), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wdata_b), .cpu_run(run_b), .pc_rst(pc_b), .load_done(done_b),
    .load_err(err_b)
  );

  // Length byte, random program, and a checksum that is either correct or guaranteed wrong.
  task automatic build_frame(input int len_byte, input bit good);
    int n;
    int s;
    int good_c;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(len_byte));
    n = (len_byte == 0) ? 256 : len_byte;
    s = 0;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      s += int'(b);
    end
    good_c = (256 - (s % 256)) % 256;
    if (good) frame_q.push_back(8'(good_c));
    else      frame_q.push_back(8'((good_c + 1 + int'($urandom_range(0, 254))) % 256));
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (rdy_a === 1'b1) ok = 1'b1;
      @(negedge clock);
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL send_byte: byte %02h never accepted, in_ready=%b required 1", b, rdy_a);
    end
  endtask

  task automatic pulse_start(input bit with_valid);
    load_start = 1'b1;
    if (with_valid) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    @(negedge clock);
    load_start = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic do_frame(input int gap_max, input bit toggle, input bit ls_noise, input bit with_valid);
    int n;
    int s;
    int g;
    bit good;
    bit ok;
    logic [7:0] ea;
    logic [7:0] eb;
    n = (frame_q[0] == 8'd0) ? 256 : int'(frame_q[0]);
    s = 0;
    for (int i = 0; i < n; i++) s += int'(frame_q[1 + i]);
    good = ((s + int'(frame_q[n + 1])) % 256) == 0;

    pulse_start(with_valid);
    total++;
    if ({rdy_a, rdy_b, run_a, run_b, done_a, done_b, err_a, err_b} !== 8'b1100_0000)
      $display("FAIL frame_open: rdy/run/done/err=%b required 11000000",
               {rdy_a, rdy_b, run_a, run_b, done_a, done_b, err_a, err_b});
    else passed++;

    for (int k = 0; k <= n + 1; k++) begin
      g = toggle ? 1 : int'($urandom_range(0, gap_max));
      for (int j = 0; j < g; j++) begin
        load_start = ls_noise && ($urandom_range(0, 3) == 0);
        @(negedge clock);
        load_start = 1'b0;
        total++;
        if ({we_a, we_b} !== 2'b00)
          $display("FAIL idle_we: byte %0d gap we=%b required 00", k, {we_a, we_b});
        else passed++;
      end
      send_byte(frame_q[k], ok);
      if (!ok) return;
      total++;
      if (k >= 1 && k <= n) begin
        ea = 8'(k - 1);
        eb = 8'(254 + k - 1);
        if ({we_a, addr_a, wdata_a, we_b, addr_b, wdata_b} !==
            {1'b1, ea, frame_q[k], 1'b1, eb, frame_q[k]})
          $display("FAIL write: byte %0d got a(%b,%02h,%02h) b(%b,%02h,%02h) required (1,%02h,%02h) (1,%02h,%02h)",
                   k, we_a, addr_a, wdata_a, we_b, addr_b, wdata_b, ea, frame_q[k], eb, frame_q[k]);
        else passed++;
      end else begin
        if ({we_a, we_b} !== 2'b00)
          $display("FAIL frame_byte_we: byte %0d we=%b required 00", k, {we_a, we_b});
        else passed++;
      end
    end

    total++;
    if (good) begin
      if ({pc_a, run_a, done_a, err_a, pc_b, run_b, done_b, err_b, rdy_a} !== 9'b1110_1110_0)
        $display("FAIL done_entry: pc/run/done/err a=%b b=%b rdy=%b required 1110 1110 0",
                 {pc_a, run_a, done_a, err_a}, {pc_b, run_b, done_b, err_b}, rdy_a);
      else passed++;
      @(negedge clock);
      total++;
      if ({pc_a, run_a, done_a, err_a, pc_b, run_b, done_b, err_b} !== 8'b0110_0110)
        $display("FAIL pc_rst_width: pc/run/done/err a=%b b=%b required 0110 0110",
                 {pc_a, run_a, done_a, err_a}, {pc_b, run_b, done_b, err_b});
      else passed++;
    end else begin
      if ({pc_a, run_a, done_a, err_a, pc_b, run_b, done_b, err_b, rdy_a} !== 9'b0001_0001_0)
        $display("FAIL error_entry: pc/run/done/err a=%b b=%b rdy=%b required 0001 0001 0",
                 {pc_a, run_a, done_a, err_a}, {pc_b, run_b, done_b, err_b}, rdy_a);
      else passed++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    load_start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clock);
    total++;
    if ({rdy_a, we_a, pc_a, done_a, err_a, run_a, addr_a, wdata_a} !== {6'b000000, 8'h00, 8'h00})
      $display("FAIL reset_a: rdy/we/pc/done/err/run=%b addr=%02h wdata=%02h required 000000,00,00",
               {rdy_a, we_a, pc_a, done_a, err_a, run_a}, addr_a, wdata_a);
    else passed++;
    total++;
    if ({rdy_b, we_b, pc_b, done_b, err_b, run_b, addr_b, wdata_b} !== {6'b000001, 8'hFE, 8'h00})
      $display("FAIL reset_b: rdy/we/pc/done/err/run=%b addr=%02h wdata=%02h required 000001,FE,00",
               {rdy_b, we_b, pc_b, done_b, err_b, run_b}, addr_b, wdata_b);
    else passed++;
    reset_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom);
      @(negedge clock);
      total++;
      if ({rdy_a, rdy_b, we_a, we_b} !== 4'b0000)
        $display("FAIL idle_no_accept: rdy/we=%b required 0000", {rdy_a, rdy_b, we_a, we_b});
      else passed++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic_frame;
    frame_q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    do_frame(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum;
    frame_q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    do_frame(1, 1'b0, 1'b0, 1'b0);
    pulse_start(1'b0);
    total++;
    if ({rdy_a, err_a, run_a, rdy_b, err_b, run_b} !== 6'b100_100)
      $display("FAIL error_restart: rdy/err/run a=%b b=%b required 100 100",
               {rdy_a, err_a, run_a}, {rdy_b, err_b, run_b});
    else passed++;
    build_frame(2, 1'b1);
    do_frame(1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_and_max_length;
    build_frame(4, 1'b1);
    do_frame(0, 1'b0, 1'b0, 1'b0);
    build_frame(0, 1'b1);
    do_frame(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_toggle_valid;
    build_frame(9, 1'b1);
    do_frame(0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_start_with_valid;
    build_frame(3, 1'b1);
    do_frame(0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random_frames;
    for (int i = 0; i < 8; i++) begin
      build_frame(int'($urandom_range(1, 20)), bit'($urandom_range(0, 1)));
      do_frame(3, 1'b0, 1'b1, bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int first_err;
    build_frame(5, 1'b1);
    pulse_start(1'b0);
    for (int k = 0; k < 3; k++) send_byte(frame_q[k], ok);
    first_err = -1;
    for (int c = 1; c <= int'(TO) + 10 && first_err < 0; c++) begin
      @(negedge clock);
      if (err_a === 1'b1) first_err = c;
    end
    total++;
    if (first_err != int'(TO))
      $display("FAIL timeout_cycle: error after %0d stalled cycles, required %0d", first_err, TO);
    else passed++;
    total++;
    if ({rdy_a, run_a, err_b, rdy_b, run_b} !== 5'b00100)
      $display("FAIL timeout_state: rdy_a/run_a/err_b/rdy_b/run_b=%b required 00100",
               {rdy_a, run_a, err_b, rdy_b, run_b});
    else passed++;
  endtask

  task automatic test_reset_mid_load;
    bit ok;
    build_frame(10, 1'b1);
    pulse_start(1'b0);
    for (int k = 0; k < 4; k++) send_byte(frame_q[k], ok);
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({we_a, we_b, rdy_a, rdy_b, run_a, run_b, addr_a, addr_b} !== {6'b000001, 8'h00, 8'hFE})
      $display("FAIL async_reset: we/rdy/run=%b addr_a=%02h addr_b=%02h required 000001,00,FE",
               {we_a, we_b, rdy_a, rdy_b, run_a, run_b}, addr_a, addr_b);
    else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    build_frame(6, 1'b1);
    do_frame(2, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time limit required");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_checksum();
    test_wrap_and_max_length();
    test_toggle_valid();
    test_start_with_valid();
    test_random_frames();
    test_timeout();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
